// File: rtl/return_fifo_gather.sv
// Byte-gathering FIFO: variable-size input chunks in, fixed-width AXI-Stream words out, with EOS flush.
// Optional macro RETURN_FIFO_STATS_EN enables the byte/stream statistics counters.
module return_fifo_gather #(
    parameter int NUM_BYTES_INPUT_WIDTH     = 16,
    parameter int NUM_BYTES_OUTPUT_WIDTH    = 8,
    parameter int FIFO_DEPTH                = 64,
    parameter int NUM_UNCOMPRESSED_ELEMENTS = 34
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_BYTES_INPUT_WIDTH*8-1:0]            dataIn,
    input  logic [$clog2(NUM_UNCOMPRESSED_ELEMENTS)-1:0]  dataInBytesValid,
    output logic                                          dataInShift,
    input  logic                                          endOfStream,
    output logic [NUM_BYTES_OUTPUT_WIDTH*8-1:0]           m_tdata,
    output logic [NUM_BYTES_OUTPUT_WIDTH-1:0]             m_tkeep,
    output logic                                          m_tlast,
    output logic                                          m_tvalid,
    input  logic                                          m_tready,
    output logic [$clog2(FIFO_DEPTH):0]                   fifoCount,
    output logic [31:0]                                   statBytesOut,
    output logic [15:0]                                   statStreamsDone
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int VW = $clog2(NUM_UNCOMPRESSED_ELEMENTS);
    localparam int NIN  = NUM_BYTES_INPUT_WIDTH;
    localparam int NOUT = NUM_BYTES_OUTPUT_WIDTH;

    localparam logic [VW:0]   NIN_V   = (VW+1)'(NIN);
    localparam logic [CW-1:0] NIN_C   = CW'(NIN);
    localparam logic [CW-1:0] NOUT_C  = CW'(NOUT);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_eosPending;
    logic [NOUT*8-1:0]   r_tdata;
    logic [NOUT-1:0]     r_tkeep;
    logic                r_tlast;
    logic                r_tvalid;

    logic                w_finalSize;
    logic [CW-1:0]       w_take;
    logic [CW-1:0]       w_space;
    logic                w_eosLatch;
    logic                w_full;
    logic                w_partial;
    logic                w_load;
    logic [CW-1:0]       w_n;
    logic                w_loadLast;
    logic [CW-1:0]       w_pushAmt;
    logic [CW-1:0]       w_popAmt;
    logic [NOUT*8-1:0]   w_word;
    logic [NOUT-1:0]     w_keep;

    // Acceptance is all-or-nothing and looks only at the registered count, so a
    // pop on the same edge never frees space for this cycle's chunk.
    always_comb begin
        w_finalSize = ({1'b0, dataInBytesValid} <= NIN_V);
        w_take      = w_finalSize ? CW'(dataInBytesValid) : NIN_C;
        w_space     = DEPTH_C - r_count;
        dataInShift = (w_take != '0) && (w_space >= w_take) && !r_eosPending;
        w_eosLatch  = endOfStream && dataInShift && w_finalSize;
        w_pushAmt   = dataInShift ? w_take : '0;
    end

    always_comb begin
        w_full     = (r_count >= NOUT_C);
        w_partial  = r_eosPending && (r_count != '0) && (r_count < NOUT_C);
        w_load     = (!r_tvalid || m_tready) && (w_full || w_partial);
        w_n        = w_full ? NOUT_C : r_count;
        w_loadLast = r_eosPending && (r_count == w_n);
        w_popAmt   = w_load ? w_n : '0;
    end

    // Gather the next output word from the oldest bytes; bytes past n read as zero.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int j = 0; j < NOUT; j++) begin
            if (CW'(j) < w_n) begin
                w_word[j*8 +: 8] = r_mem[r_rptr + PW'(j)];
                w_keep[j]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dataInShift) begin
            for (int i = 0; i < NIN; i++) begin
                if (CW'(i) < w_take) begin
                    r_mem[r_wptr + PW'(i)] <= dataIn[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_eosPending <= 1'b0;
            r_tdata      <= '0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_tvalid     <= 1'b0;
        end else begin
            if (dataInShift) begin
                r_wptr <= r_wptr + w_take[PW-1:0];
            end
            if (w_load) begin
                r_rptr <= r_rptr + w_n[PW-1:0];
            end
            r_count <= r_count + w_pushAmt - w_popAmt;

            if (w_eosLatch) begin
                r_eosPending <= 1'b1;
            end else if (w_load && w_loadLast) begin
                r_eosPending <= 1'b0;
            end

            // A held beat stays untouched until the consumer takes it.
            if (w_load) begin
                r_tdata  <= w_word;
                r_tkeep  <= w_keep;
                r_tlast  <= w_loadLast;
                r_tvalid <= 1'b1;
            end else if (m_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign m_tdata   = r_tdata;
    assign m_tkeep   = r_tkeep;
    assign m_tlast   = r_tlast;
    assign m_tvalid  = r_tvalid;
    assign fifoCount = r_count;

`ifdef RETURN_FIFO_STATS_EN
    logic [31:0] r_statBytes;
    logic [15:0] r_statStreams;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_statBytes   <= '0;
            r_statStreams <= '0;
        end else if (r_tvalid && m_tready) begin
            r_statBytes <= r_statBytes + 32'($countones(r_tkeep));
            if (r_tlast) begin
                r_statStreams <= r_statStreams + 16'd1;
            end
        end
    end

    assign statBytesOut    = r_statBytes;
    assign statStreamsDone = r_statStreams;
`else
    assign statBytesOut    = '0;
    assign statStreamsDone = '0;
`endif

endmodule

// File: tb/tb_return_fifo_gather.sv
// Scoreboard bench for return_fifo_gather: randomized chunked streams against a byte-queue reference.
// Statistics expectations follow RETURN_FIFO_STATS_EN.
module tb_return_fifo_gather;

    localparam int NIN   = 16;
    localparam int NOUT  = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [127:0]  dataIn;
    logic [5:0]    dataInBytesValid;
    logic          dataInShift;
    logic          endOfStream;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [6:0]    fifoCount;
    logic [31:0]   statBytesOut;
    logic [15:0]   statStreamsDone;

    int checks   = 0;
    int failures = 0;
    int readyMode = 2;
    int streamsDone = 0;
    int modelStatBytes = 0;
    int modelStatStreams = 0;
    logic [7:0] expBytes[$];
    bit         expLast[$];

    return_fifo_gather dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .dataInBytesValid(dataInBytesValid),
        .dataInShift(dataInShift), .endOfStream(endOfStream), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .fifoCount(fifoCount), .statBytesOut(statBytesOut), .statStreamsDone(statStreamsDone)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic int minInt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Consumer readiness: 0 = always ready, 1 = random, other = stalled.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
        end
    end

    // Monitor: each accepted beat takes up to NOUT bytes from the reference
    // stream, stopping early after the final byte of a stream.
    initial begin
        logic [63:0] expData;
        logic [7:0]  expKeep;
        bit          lastSeen;
        int          k;
        forever begin
            @(negedge clk);
            if (!reset && m_tvalid && m_tready) begin
                if (expBytes.size() == 0) begin
                    checkOutput("unexpected_beat", {m_tdata, m_tkeep, m_tlast}, '0);
                end else begin
                    expData = '0;
                    k = 0;
                    lastSeen = 1'b0;
                    while (k < NOUT && expBytes.size() > 0 && !lastSeen) begin
                        expData[k*8 +: 8] = expBytes.pop_front();
                        lastSeen = expLast.pop_front();
                        k++;
                    end
                    expKeep = 8'((16'd1 << k) - 16'd1);
                    checkOutput("beat", {m_tdata, m_tkeep, m_tlast}, {expData, expKeep, lastSeen});
                    modelStatBytes += k;
                    if (lastSeen) begin
                        streamsDone++;
                        modelStatStreams++;
                    end
                end
            end
        end
    end

    // Sends one stream of len bytes starting at value startVal; chunkMax <= 0
    // picks a random chunk size (1..33) each cycle. Waits until its last beat is taken.
    task automatic applyStimulus(input int len, input int chunkMax, input int startVal);
        int remaining = len;
        int pos = 0;
        int guard = 0;
        int valid, take, target;
        bit eosFlag;
        target = streamsDone + 1;
        while (remaining > 0 && guard < 5000) begin
            valid   = minInt((chunkMax > 0) ? chunkMax : int'($urandom_range(1, 33)), remaining);
            eosFlag = (valid == remaining);
            for (int i = 0; i < NIN; i++)
                dataIn[i*8 +: 8] = (i < valid) ? 8'(startVal + pos + i) : 8'($urandom);
            dataInBytesValid = 6'(valid);
            endOfStream      = eosFlag;
            @(negedge clk);
            take = minInt(valid, NIN);
            checkOutput("dataInShift_rule", 128'(dataInShift), 128'((DEPTH - int'(fifoCount)) >= take));
            if (dataInShift) begin
                for (int i = 0; i < take; i++) begin
                    expBytes.push_back(8'(startVal + pos + i));
                    expLast.push_back(eosFlag && (valid <= NIN) && (i == take - 1));
                end
                pos       += take;
                remaining -= take;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (remaining > 0) checkOutput("send_timeout", 128'(remaining), 128'(0));
        // Offer a follow-on chunk while the flush is pending; it must be refused.
        dataInBytesValid = 6'd8;
        endOfStream      = 1'b0;
        guard = 0;
        while (guard < 5000) begin
            @(negedge clk);
            if (m_tvalid && m_tlast) break;
            checkOutput("shift_blocked_eos", 128'(dataInShift), 128'(0));
            guard++;
        end
        dataInBytesValid = 6'd0;
        if (guard >= 5000) checkOutput("tlast_load_timeout", 128'(guard), 128'(0));
        guard = 0;
        while (streamsDone < target && guard < 5000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (streamsDone < target) checkOutput("stream_done_timeout", 128'(streamsDone), 128'(target));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] expWord;
        reset = 1'b0;
        dataIn = '0;
        dataInBytesValid = 6'd5;
        endOfStream = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_tvalid", 128'(m_tvalid), 128'(0));
        checkOutput("reset_fifoCount", 128'(fifoCount), 128'(0));
        checkOutput("reset_outputs", {m_tdata, m_tkeep, m_tlast}, '0);
        checkOutput("reset_shift_rule", 128'(dataInShift), 128'(1));
        dataInBytesValid = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        readyMode = 0;
        applyStimulus(20, 20, 8'h00);
        applyStimulus(20, 20, 8'h00);
`ifdef RETURN_FIFO_STATS_EN
        checkOutput("stats_bytes_two_streams", 128'(statBytesOut), 128'(40));
        checkOutput("stats_streams_two", 128'(statStreamsDone), 128'(2));
`else
        checkOutput("stats_bytes_tied", 128'(statBytesOut), 128'(0));
        checkOutput("stats_streams_tied", 128'(statStreamsDone), 128'(0));
`endif

        // Exact multiple of the output width.
        applyStimulus(24, 8, 8'hA0);

        // endOfStream with nothing offered must be ignored.
        dataInBytesValid = 6'd0;
        endOfStream = 1'b1;
        @(negedge clk);
        checkOutput("eos_zero_ignored", 128'(dataInShift), 128'(0));
        @(posedge clk);
        #1;
        endOfStream = 1'b0;

        // Backpressure: the consumer stalls for 12 cycles while chunks of 16 arrive.
        readyMode = 2;
        fork
            applyStimulus(64, 16, 8'h40);
            begin
                repeat (6) @(negedge clk);
                for (int i = 0; i < NOUT; i++) expWord[i*8 +: 8] = 8'(8'h40 + i);
                checkOutput("stall_data_early", 128'(m_tdata), 128'(expWord));
                repeat (6) @(negedge clk);
                checkOutput("stall_fifoCount", 128'(fifoCount), 128'(56));
                checkOutput("stall_shift_refused", 128'(dataInShift), 128'(0));
                checkOutput("stall_tvalid", 128'(m_tvalid), 128'(1));
                checkOutput("stall_data_late", 128'(m_tdata), 128'(expWord));
                readyMode = 0;
            end
        join

        // Long stream with odd chunks so the storage wraps many times.
        readyMode = 1;
        applyStimulus(300, 7, 8'h00);
        for (int s = 0; s < 6; s++)
            applyStimulus(int'($urandom_range(1, 80)), 0, int'($urandom_range(0, 255)));

        // Abort mid-stream: accumulate some bytes behind a stalled consumer, then reset between edges.
        readyMode = 2;
        dataInBytesValid = 6'd16;
        for (int i = 0; i < NIN; i++) dataIn[i*8 +: 8] = 8'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_tvalid", 128'(m_tvalid), 128'(0));
        checkOutput("abort_fifoCount", 128'(fifoCount), 128'(0));
        checkOutput("abort_outputs", {m_tdata, m_tkeep, m_tlast}, '0);
        checkOutput("abort_shift_rule", 128'(dataInShift), 128'(1));
        expBytes.delete();
        expLast.delete();
        modelStatBytes = 0;
        modelStatStreams = 0;
        dataInBytesValid = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        readyMode = 1;
        applyStimulus(10, 3, 8'h80);
`ifdef RETURN_FIFO_STATS_EN
        checkOutput("stats_bytes_after_reset", 128'(statBytesOut), 128'(modelStatBytes));
        checkOutput("stats_streams_after_reset", 128'(statStreamsDone), 128'(modelStatStreams));
`else
        checkOutput("stats_bytes_tied_end", 128'(statBytesOut), 128'(0));
        checkOutput("stats_streams_tied_end", 128'(statStreamsDone), 128'(0));
`endif
        checkOutput("drained_queue", 128'(expBytes.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
